// File: rtl/approx_adder_pkg.sv
// Shared types and constants for the approximate-adder arbiter and its core.
// The FSM state encoding, the LSB inversion mask helper and default sizes.
package approx_adder_pkg;

    localparam int DEFAULT_WIDTH       = 16;
    localparam int DEFAULT_LOWER_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    function automatic logic [63:0] lsb_mask(input int lw);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < lw) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/approx_cla_core.sv
// Combinational carry-lookahead adder with exact carries and XNOR sum cells
// in the LOWER_WIDTH least significant bits; exact_i disables the approximation.
module approx_cla_core
    import approx_adder_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int LOWER_WIDTH = DEFAULT_LOWER_WIDTH
) (
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic             exact_i,
    output logic [WIDTH:0]   result_o
);

    if (LOWER_WIDTH > WIDTH || LOWER_WIDTH < 0) begin : g_bad_lower_width
        $error("approx_cla_core: LOWER_WIDTH must be within 0..WIDTH");
    end

    localparam logic [WIDTH-1:0] MASK = WIDTH'(lsb_mask(LOWER_WIDTH));

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_sum;

    assign w_g = add1_i & add2_i;
    assign w_p = add1_i | add2_i;

    always_comb begin
        w_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
    end

    // Inverting the low sum bits is exactly an XNOR cell there.
    assign w_mask   = exact_i ? '0 : MASK;
    assign w_sum    = add1_i ^ add2_i ^ w_c[WIDTH-1:0] ^ w_mask;
    assign result_o = {w_c[WIDTH], w_sum};

endmodule

// File: rtl/approx_adder_arbiter.sv
// Round-robin front end sharing one approximate adder core among NUM_REQ requesters.
// Define EXACT_MODE_EN to add per-request exact selection (req_exact_i / rsp_exact_o).
// state | meaning
// IDLE  | grant the next valid requester, capture its operands
// EVAL  | core evaluates captured operands, result registered
// HOLD  | result presented until consumed
module approx_adder_arbiter
    import approx_adder_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int LOWER_WIDTH = DEFAULT_LOWER_WIDTH,
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_add1_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_add2_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [WIDTH:0]           rsp_result_o,
    output logic [ID_W-1:0]          rsp_id_o,
`ifdef EXACT_MODE_EN
    input  logic [NUM_REQ-1:0]       req_exact_i,
    output logic                     rsp_exact_o,
`endif
    output logic                     busy_o
);

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("approx_adder_arbiter: NUM_REQ must be at least 2");
    end

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    state_e           r_state;
    state_e           w_state_nxt;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [WIDTH-1:0] r_add1;
    logic [WIDTH-1:0] r_add2;
    logic [ID_W-1:0]  r_id;
    logic             r_exact;
    logic [WIDTH:0]   r_result;

    logic [NUM_REQ-1:0] w_rot;
    logic               w_found;
    int                 w_off;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_accept;
    logic               w_exact_in;
    logic [WIDTH:0]     w_core_result;

    // Rotate so rr_ptr is bit 0, take the lowest set bit, rotate the index back.
    always_comb begin
        w_rot = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_rot[j] = req_valid_i[wrap_add(r_rr_ptr, j)];
        end
        w_found = |w_rot;
        w_off   = 0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) w_off = j;
        end
        w_grant_id = wrap_add(r_rr_ptr, w_off);
    end

    assign w_accept = (r_state == ST_IDLE) && w_found;

    always_comb begin
        req_ready_o = '0;
        if (rst_ni && w_accept) req_ready_o[w_grant_id] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        rsp_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (w_found) w_state_nxt = ST_EVAL;
            end
            ST_EVAL: w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef EXACT_MODE_EN
    assign w_exact_in  = req_exact_i[w_grant_id];
    assign rsp_exact_o = r_exact;
`else
    assign w_exact_in  = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_add1   <= '0;
            r_add2   <= '0;
            r_id     <= '0;
            r_exact  <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_add1   <= req_add1_i[int'(w_grant_id)*WIDTH +: WIDTH];
                r_add2   <= req_add2_i[int'(w_grant_id)*WIDTH +: WIDTH];
                r_id     <= w_grant_id;
                r_exact  <= w_exact_in;
                r_rr_ptr <= wrap_add(w_grant_id, 1);
            end
            if (r_state == ST_EVAL) r_result <= w_core_result;
        end
    end

    approx_cla_core #(
        .WIDTH       (WIDTH),
        .LOWER_WIDTH (LOWER_WIDTH)
    ) u_core (
        .add1_i   (r_add1),
        .add2_i   (r_add2),
        .exact_i  (r_exact),
        .result_o (w_core_result)
    );

    assign rsp_result_o = r_result;
    assign rsp_id_o     = r_id;

endmodule

// File: tb/tb_approx_adder_arbiter.sv
// Scoreboard bench for approx_adder_arbiter: directed requests push expected
// responses, a negedge monitor pops and compares on every consumed result.
module tb_approx_adder_arbiter;

    logic        clk_i;
    logic        rst_ni;
    logic [3:0]  req_valid_i;
    logic [3:0]  req_ready_o;
    logic [63:0] req_add1_i;
    logic [63:0] req_add2_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [16:0] rsp_result_o;
    logic [1:0]  rsp_id_o;
    logic        busy_o;
`ifdef EXACT_MODE_EN
    logic [3:0]  req_exact_i;
    logic        rsp_exact_o;
`endif

    logic [15:0] ex_a;
    logic [15:0] ex_b;
    logic [16:0] ex_res;

    typedef struct {
        logic [16:0] res;
        logic [1:0]  id;
        logic        ex;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    approx_adder_arbiter dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_add1_i   (req_add1_i),
        .req_add2_i   (req_add2_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_result_o (rsp_result_o),
        .rsp_id_o     (rsp_id_o),
`ifdef EXACT_MODE_EN
        .req_exact_i  (req_exact_i),
        .rsp_exact_o  (rsp_exact_o),
`endif
        .busy_o       (busy_o)
    );

    approx_cla_core #(.WIDTH(16), .LOWER_WIDTH(0)) u_exact_core (
        .add1_i   (ex_a),
        .add2_i   (ex_b),
        .exact_i  (1'b0),
        .result_o (ex_res)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && rsp_valid_o && rsp_ready_i) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got id %0d result 0x%0h, expected no response",
                         rsp_id_o, rsp_result_o);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rsp_result", 32'(rsp_result_o), 32'(mon_e.res));
                chk("rsp_id", 32'(rsp_id_o), 32'(mon_e.id));
`ifdef EXACT_MODE_EN
                chk("rsp_exact", 32'(rsp_exact_o), 32'(mon_e.ex));
`endif
            end
        end
    end

    task automatic issue(input int k, input logic [15:0] a, input logic [15:0] b,
                         input logic [16:0] res, input logic ex, input bit push);
        int n;
        exp_t e;
        req_add1_i[k*16 +: 16] = a;
        req_add2_i[k*16 +: 16] = b;
`ifdef EXACT_MODE_EN
        req_exact_i[k] = ex;
`endif
        req_valid_i    = 4'b0;
        req_valid_i[k] = 1'b1;
        n = 0;
        #1;
        while (!req_ready_o[k] && n < 40) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!req_ready_o[k]) begin
            total++;
            bad++;
            $display("FAIL grant_timeout: requester %0d got no grant, required a grant", k);
        end else if (push) begin
            e.res = res;
            e.id  = 2'(k);
            e.ex  = ex;
            sb_q.push_back(e);
        end
        @(posedge clk_i); #1;
        req_valid_i = 4'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_o || sb_q.size() != 0) && n < 60) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (busy_o || sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy=%0d pending=%0d, required 0 and 0", busy_o, sb_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          rr_exp[5];
    logic [16:0] rr_res[4];

    initial begin
        int   g;
        int   c;
        int   last_c;
        exp_t e;

        rr_exp = '{0, 1, 2, 3, 0};
        rr_res = '{17'h0001F, 17'h1000F, 17'h000F0, 17'h0BE0E};

        rst_ni      = 1'b0;
        rsp_ready_i = 1'b1;
        req_valid_i = 4'hF;
        req_add1_i  = '0;
        req_add2_i  = '0;
`ifdef EXACT_MODE_EN
        req_exact_i = '0;
`endif
        req_add1_i[15:0] = 16'h1234;
        req_add2_i[15:0] = 16'h1111;
        ex_a = 16'h1234;
        ex_b = 16'h1111;

        // Reset with every requester valid
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_ready", 32'(req_ready_o), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("reset_busy", 32'(busy_o), 32'h0);
        chk("exact_core_a", 32'(ex_res), 32'h02345);
        ex_a = 16'hFFFF;
        ex_b = 16'h0001;
        @(posedge clk_i); #1;
        chk("exact_core_b", 32'(ex_res), 32'h10000);
        rst_ni = 1'b1;
        #1;
        chk("first_grant", 32'(req_ready_o), 32'h1);
        e.res = 17'h0234A; e.id = 2'd0; e.ex = 1'b0;
        sb_q.push_back(e);
        @(posedge clk_i); #1;
        req_valid_i = 4'b0;
        wait_idle();

        // Single request from requester 2, with latency check
        issue(2, 16'h0000, 16'h0000, 17'h0000F, 1'b0, 1'b1);
        @(negedge clk_i);
        chk("lat_eval_valid", 32'(rsp_valid_o), 32'h0);
        chk("lat_eval_busy", 32'(busy_o), 32'h1);
        @(negedge clk_i);
        chk("lat_hold_valid", 32'(rsp_valid_o), 32'h1);
        wait_idle();

        // Carry-out case and a pointer wrap (3 -> 0)
        issue(3, 16'hFFFF, 16'h0001, 17'h1000F, 1'b0, 1'b1);
        wait_idle();
        issue(0, 16'h7FFF, 16'h0001, 17'h0800F, 1'b0, 1'b1);
        wait_idle();

        // Back-pressure in HOLD; requester 3 waits ungranted then withdraws
        rsp_ready_i = 1'b0;
        issue(1, 16'hABCD, 16'h1234, 17'h0BE0E, 1'b0, 1'b1);
        req_add1_i[63:48] = 16'h5555;
        req_valid_i = 4'b1000;
        @(negedge clk_i);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("bp_valid", 32'(rsp_valid_o), 32'h1);
            chk("bp_result", 32'(rsp_result_o), 32'h0BE0E);
            chk("bp_id", 32'(rsp_id_o), 32'h1);
            chk("bp_ready", 32'(req_ready_o), 32'h0);
        end
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b1;
        req_valid_i = 4'b0;
        @(posedge clk_i); #1;
        chk("bp_idle_after", 32'(busy_o), 32'h0);
        chk("bp_valid_after", 32'(rsp_valid_o), 32'h0);

        // Reset while in EVAL: nothing emitted, pointer back to 0
        issue(2, 16'h1111, 16'h2222, 17'h0, 1'b0, 1'b0);
        rst_ni = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy_o), 32'h0);
        @(negedge clk_i);
        chk("midrst_valid", 32'(rsp_valid_o), 32'h0);
        repeat (2) @(posedge clk_i);
        #1;

        // Round robin with all requesters valid continuously
        req_add1_i[15:0]  = 16'h000F; req_add2_i[15:0]  = 16'h0001;
        req_add1_i[31:16] = 16'h8000; req_add2_i[31:16] = 16'h8000;
        req_add1_i[47:32] = 16'h00F0; req_add2_i[47:32] = 16'h000F;
        req_add1_i[63:48] = 16'hABCD; req_add2_i[63:48] = 16'h1234;
        req_valid_i = 4'hF;
        rst_ni      = 1'b1;
        g      = 0;
        c      = 0;
        last_c = 0;
        while (g < 5 && c < 40) begin
            @(negedge clk_i);
            if (req_ready_o != 4'b0) begin
                chk("rr_onehot", 32'($onehot(req_ready_o)), 32'h1);
                chk("rr_order", 32'(req_ready_o), 32'h1 << rr_exp[g]);
                if (g > 0) chk("rr_spacing", 32'(c - last_c), 32'd3);
                e.res = rr_res[rr_exp[g]];
                e.id  = 2'(rr_exp[g]);
                e.ex  = 1'b0;
                sb_q.push_back(e);
                last_c = c;
                g++;
            end
            c++;
        end
        if (g < 5) begin
            total++;
            bad++;
            $display("FAIL rr_timeout: saw %0d grants, required 5", g);
        end
        @(posedge clk_i); #1;
        req_valid_i = 4'b0;
        wait_idle();

`ifdef EXACT_MODE_EN
        issue(0, 16'h0003, 16'h0004, 17'h00007, 1'b1, 1'b1);
        wait_idle();
        issue(0, 16'h0003, 16'h0004, 17'h00008, 1'b0, 1'b1);
        wait_idle();
`endif

        repeat (3) @(posedge clk_i);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
